network_controller: RTL
=======================

// Module: network_controller
// PURPOSE
//  Sequences a chain of dense_layer instances for one inference per input sample.
//  Accepts a sample via valid/ready, clears all layers, then starts each layer in order.
//  Waits on each layer's outputs_ready before starting the next, then presents the
//  final layer's result downstream via valid/ready. Also measures inference latency
//  and flags hung layers. Sits between the sample source and the dense_layer chain.
// PARAMETERS
//  NUM_LAYERS     3      number of dense layers sequenced (>=1)
//  TIMEOUT_CYCLES 4096   max cycles a layer may take after its start pulse
//  COUNT_WIDTH    32     width of the latency counter
// PORTS
//  clock          in   1             single clock, all logic rising-edge
//  reset          in   1             synchronous, active-low reset
//  in_valid       in   1             upstream sample available
//  in_ready       out  1             controller can accept a sample
//  in_load        out  1             1-cycle enable: capture sample into layer-0 input register
//  layer_clear    out  1             1-cycle synchronous clear to all layers' neurons
//  layer_start    out  NUM_LAYERS    1-cycle inputs_ready pulse, one bit per layer
//  layer_done     in   NUM_LAYERS    outputs_ready from each layer (level)
//  out_valid      out  1             final-layer outputs valid
//  out_ready      in   1             downstream accepts result
//  busy           out  1             high in any state except IDLE
//  active_layer   out  $clog2(NUM_LAYERS)+1  index of layer currently running
//  latency        out  COUNT_WIDTH   cycles from accept to out_valid, last inference
//  timeout_err    out  1             sticky: a layer exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (reset==0 at a clock edge): state IDLE; every output 0 except in_ready=1.
//   Reset overrides all activity mid-inference. No pulse is emitted in the reset cycle.
//  FSM states:
//   IDLE   in_ready=1. On in_valid: in_load=1 this cycle, latency counter cleared, go CLEAR.
//   CLEAR  layer_clear=1 for one cycle; k=0; go START.
//   START  layer_start[k]=1 for one cycle; watchdog cleared; go WAIT.
//          layer_done is ignored in START.
//   WAIT   If layer_done[k]=1 and k<NUM_LAYERS-1: k++, go START.
//          If layer_done[k]=1 and k==NUM_LAYERS-1: go OUTPUT.
//          If watchdog reaches TIMEOUT_CYCLES first: set timeout_err, go ERROR.
//          done and timeout in the same cycle -> done wins.
//   OUTPUT out_valid=1, held until out_ready. On the out_valid&&out_ready cycle: go IDLE.
//          latency is frozen on entry to OUTPUT.
//   ERROR  out_valid=0, in_ready=0; layer_clear pulses once on entry.
//          Stays in ERROR until reset.
//  Outputs are registered: outputs change one cycle after the state decision.
//  Done bits of layers other than k are ignored.
//  Latency counter: counts every cycle from the IDLE accept edge to OUTPUT entry.
//   Saturates at all-ones and does not wrap.
//  Minimum latency for NUM_LAYERS=N with layers done 1 cycle after start: 1+2N+... (exact value per TESTING).
//  in_valid is never accepted while busy; an in_valid held high across OUTPUT->IDLE
//   is accepted on the first IDLE cycle (no back-to-back in the OUTPUT handshake cycle).
//  active_layer = k in START and WAIT, NUM_LAYERS in OUTPUT, 0 otherwise.
// STRUCTURE
//  nn_pkg: ACTIVATION enum (moved from global scope) and ctrl_state_t enum
//   {IDLE, CLEAR, START, WAIT, OUTPUT, ERROR}; all dense_layer users import it.
//  Sub-module layer_watchdog (params TIMEOUT_CYCLES): inputs clear and enable;
//   output expired; $clog2(TIMEOUT_CYCLES+1)-bit saturating counter.
//  Controller FSM, layer index, latency counter and output registers live in this module.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles mid-WAIT -> IDLE, in_ready=1, all pulses 0, timeout_err=0.
//  2 NUM_LAYERS=3, each layer_done rises 5 cycles after its start pulse -> starts seen in order 0,1,2,
//    each exactly 1 cycle wide; single layer_clear before start[0]; out_valid; latency=20.
//  3 Backpressure: out_ready=0 for 10 cycles -> out_valid held and latency unchanged;
//    in_valid=1 ignored; accept occurs the cycle after the out handshake.
//  4 Stale done: layer_done[1]=1 throughout the run -> no advance from layer 1 before
//    the start[1] pulse; done in the START cycle is ignored.
//  5 Timeout: TIMEOUT_CYCLES=16, layer_done[1] never rises -> timeout_err=1 at cycle 16 after start[1];
//    ERROR with 1 layer_clear pulse; a later in_valid is not accepted; reset clears timeout_err.
//  6 Tie: layer_done[k] rises in the same cycle the watchdog expires -> advance, timeout_err=0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types for the dense_layer chain and its sequencing controller.
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR,
    ACT_RELU,
    ACT_SIGMOID,
    ACT_TANH
  } ACTIVATION;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    WAIT,
    OUTPUT,
    ERROR
  } ctrl_state_t;

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer hang detector: counts enabled cycles since the last clear and flags
// the TIMEOUT_CYCLES-th one, so a layer gets exactly TIMEOUT_CYCLES cycles after its start.
module layer_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && cnt_q != LIMIT)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // cnt_q holds the number of earlier enabled cycles, so the current one is cnt_q+1.
  assign expired_o = enable_i && (cnt_q >= LIMIT - CW'(1));

endmodule

// File: rtl/network_controller.sv
// Sequences one inference through a chain of dense layers: load, clear, start each
// layer in turn, present the result, and record latency / hung-layer errors.
module network_controller
  import nn_pkg::*;
#(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic                          in_load_o,
  output logic                          layer_clear_o,
  output logic [NUM_LAYERS-1:0]         layer_start_o,
  input  logic [NUM_LAYERS-1:0]         layer_done_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic [$clog2(NUM_LAYERS):0]   active_layer_o,
  output logic [COUNT_WIDTH-1:0]        latency_o,
  output logic                          timeout_err_o
);

  localparam int AW = $clog2(NUM_LAYERS) + 1;

  ctrl_state_t            state_q;
  logic [NUM_LAYERS-1:0]  sel_q;
  logic [AW-1:0]          active_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, latency_q;
  logic                   in_ready_q, in_load_q, layer_clear_q, out_valid_q;
  logic                   busy_q, terr_q;
  logic [NUM_LAYERS-1:0]  layer_start_q;
  logic                   done_hit, last_layer, wd_expired;

  // Only the running layer's done bit matters; stale bits from others are masked.
  assign done_hit   = |(layer_done_i & sel_q);
  assign last_layer = sel_q[NUM_LAYERS-1];
  assign cnt_d      = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);

  layer_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i     (clock_i),
    .rst_ni    (reset_ni),
    .clear_i   (state_q == START),
    .enable_i  (state_q == WAIT),
    .expired_o (wd_expired)
  );

  // Outputs are registered from the next state, so they are valid while in that state.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      active_q      <= '0;
      cnt_q         <= '0;
      latency_q     <= '0;
      in_ready_q    <= 1'b1;
      in_load_q     <= 1'b0;
      layer_clear_q <= 1'b0;
      layer_start_q <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      in_load_q     <= 1'b0;
      layer_clear_q <= 1'b0;
      layer_start_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q       <= CLEAR;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b1;
            in_load_q     <= 1'b1;
            layer_clear_q <= 1'b1;
            cnt_q         <= COUNT_WIDTH'(1);
          end
        end
        CLEAR: begin
          state_q       <= START;
          sel_q         <= NUM_LAYERS'(1);
          layer_start_q <= NUM_LAYERS'(1);
          active_q      <= '0;
          cnt_q         <= cnt_d;
        end
        START: begin
          state_q <= WAIT;
          cnt_q   <= cnt_d;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (done_hit) begin
            if (last_layer) begin
              state_q     <= OUTPUT;
              out_valid_q <= 1'b1;
              active_q    <= AW'(NUM_LAYERS);
              latency_q   <= cnt_d;
            end else begin
              state_q       <= START;
              sel_q         <= sel_q << 1;
              layer_start_q <= sel_q << 1;
              active_q      <= active_q + AW'(1);
            end
          end else if (wd_expired) begin
            state_q       <= ERROR;
            terr_q        <= 1'b1;
            layer_clear_q <= 1'b1;
            active_q      <= '0;
          end
        end
        OUTPUT: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            active_q    <= '0;
          end
        end
        ERROR: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign in_load_o      = in_load_q;
  assign layer_clear_o  = layer_clear_q;
  assign layer_start_o  = layer_start_q;
  assign out_valid_o    = out_valid_q;
  assign busy_o         = busy_q;
  assign active_layer_o = active_q;
  assign latency_o      = latency_q;
  assign timeout_err_o  = terr_q;

endmodule
